mem_stage_vl: RTL and testbench
===============================

# mem_stage_vl

Variable-latency memory stage for the 5-stage MIPS pipeline, between EX and WB. It accepts an instruction from EX whose data request (if any) was already address-accepted by the data SRAM-like bus. It holds the instruction until the in-order `data_ok` response returns, then aligns and sign/zero-extends load data (W/H/B/LWL/LWR) and forwards the result to WB and to ID/EX bypass. After an exception flush from WB it discards stale responses so they never reach a younger instruction.

## Interface
Parameters:
- `DISCARD_MAX`, 3: maximum number of stale responses tracked; the counter width is clog2(`DISCARD_MAX`+1).
- `BUF_RDATA`, 1: 1 registers `rdata` on `data_ok` when WB stalls; 0 requires `ws_allowin` whenever `data_ok` can occur (verification-only mode).

Ports:
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `es_to_ms_valid` in 1: EX presents an instruction.
- `ms_allowin` out 1: MEM accepts from EX this cycle.
- `es_pc` in 32: instruction PC.
- `es_dest` in 5: destination GPR.
- `es_gr_we` in 1: GPR write enable.
- `es_alu_result` in 32: ALU result or effective address.
- `es_rt_value` in 32: old rt, used to merge LWL/LWR.
- `es_ld_op` in 3: load opcode. 0 none, 1 W, 2 H, 3 B, 4 LWL, 5 LWR.
- `es_ld_sign` in 1: sign-extend H/B.
- `es_mem_req` in 1: this instruction owns one outstanding response.
- `es_ex` in 1: exception flag.
- `es_excode` in 5: exception code.
- `es_req_inflight` in 1: EX holds an accepted request that has not yet moved to MEM.
- `data_sram_data_ok` in 1: response strobe, in order.
- `data_sram_rdata` in 32: response data.
- `ws_allowin` in 1: WB accepts.
- `ms_to_ws_valid` out 1: result valid to WB.
- `ms_pc` out 32, `ms_dest` out 5, `ms_gr_we` out 1, `ms_final_result` out 32, `ms_ex` out 1, `ms_excode` out 5: WB payload.
- `ms_fwd_valid` out 1: `ms_valid` && `ms_gr_we`.
- `ms_fwd_blocked` out 1: result not yet available; ID must stall on a match.
- `ex_to_es` out 1: `ms_valid` && `ms_ex`; EX must suppress its own memory request.
- `ex_from_ws` in 1: flush.
- `ms_discard_busy` out 1: discard count is nonzero; EX must not issue new requests.

## Operation
- State, per held instruction:
  - NOMEM: no response owed.
  - WAIT: response owed, not yet received.
  - DONE: response captured in `rdata_buf`.
- On accept (`es_to_ms_valid` && `ms_allowin`), latch all `es_*` fields. The state goes to WAIT if `es_mem_req` && !`es_ex`, else NOMEM.
- A `data_ok` is claimed by the discard counter first. If the count is greater than 0, decrement and ignore the data.
- Otherwise, in WAIT, the response belongs to MEM:
  - `ms_ready_go` asserts that cycle, with data taken combinationally from `data_sram_rdata`.
  - If !`ws_allowin`, capture it into `rdata_buf` and go to DONE.
- `ms_ready_go` = NOMEM | DONE | (WAIT && `data_ok` && count==0).
- `ms_allowin` = !`ms_valid` | (`ms_ready_go` && `ws_allowin`).
- `ms_to_ws_valid` = `ms_valid` && `ms_ready_go`.
- Flush (`ex_from_ws`):
  - `ms_valid` is cleared and the state goes to NOMEM.
  - Next count = count + (`ms_valid` && WAIT) + `es_req_inflight` − (`data_ok` && count>0).
  - A `data_ok` in the flush cycle with count==0 belongs to the flushed MEM instruction and is consumed. In that case the WAIT term is not added.
  - Exceeding `DISCARD_MAX` is a protocol error and triggers an assertion.
- Load alignment uses the offset `a` = `alu_result[1:0]`:
  - H: half `a[1]`. B: byte `a`. Sign or zero extension per `ld_sign`.
  - LWL, memory bytes into upper result: a=0 gives {r[7:0],rt[23:0]}; a=1 gives {r[15:0],rt[15:0]}; a=2 gives {r[23:0],rt[7:0]}; a=3 gives r.
  - LWR: a=0 gives r; a=1 gives {rt[31:24],r[31:8]}; a=2 gives {rt[31:16],r[31:16]}; a=3 gives {rt[31:8],r[31:24]}.
  - Op 0 passes `alu_result` through.
- `ms_fwd_blocked` = `ms_valid` && `ld_op`≠0 && !`ms_ready_go`.
- `ex_to_es` is independent of `ms_ready_go`.

## Timing
- Reset values:
  - `ms_valid`=0, state NOMEM, discard count 0.
  - Every output is 0 except `ms_allowin`=1.
- Latency: 0 cycles from `data_ok` to `ms_to_ws_valid` (combinational path). Non-memory instructions pass in 1 cycle.
- Flush has priority over accept in the same cycle. The instruction offered by EX in the flush cycle is not latched.
- A reset during WAIT or during a discard clears the count. The bus is reset together with the pipeline.
- Simultaneous `data_ok`, flush and `es_req_inflight` follow the count formula exactly.

## Structure
- Shared package `mycpu.h`: the `LD_*` opcode constants, `ES_TO_MS`/`MS_TO_WS` bus widths, and excode constants.
- One combinational sub-module, `load_align`. Inputs are `ld_op`, `ld_sign`, `addr[1:0]`, `rdata` and `rt`; output is `result`. It is reused by a future cache refill path.

## Test plan
- **LW, 3-cycle latency:** LW at addr 0x1000; `data_ok` 3 cycles later with rdata 0xDEADBEEF. Expect `ms_fwd_blocked`=1 for 3 cycles, then `ms_final_result`=0xDEADBEEF with `ms_to_ws_valid` in the `data_ok` cycle.
- **LB / LBU, offset 3:** rdata 0x80123456. LB gives 0xFFFFFF80; LBU gives 0x00000080.
- **LWL / LWR, offset 1:** rdata 0xAABBCCDD, rt 0x11223344. LWL gives 0xCCDD3344; LWR gives 0x11AABBCC.
- **Flush during WAIT:** flush while MEM is in WAIT and `es_req_inflight`=1. Expect count=2 and `ms_discard_busy`=1. The next two `data_ok` are dropped. A following LW receives only the third response.
- **WB backpressure:** `ws_allowin`=0 during `data_ok`. Expect state DONE and `rdata_buf` held; bus rdata changes to 0x0 with no effect. Raise `ws_allowin`; expect the original value delivered.
- **Flush coincident with `data_ok`, count 0:** expect count stays 0, `ms_valid`=0, and nothing forwarded to WB.

Source files
------------

// File: rtl/mem_stage_vl_pkg.sv
// Shared MEM-stage definitions: load opcodes, EX->MEM / MEM->WB payload layouts,
// exception codes and the per-instruction response state.
package mem_stage_vl_pkg;

    localparam logic [2:0] LD_NONE = 3'd0;
    localparam logic [2:0] LD_W    = 3'd1;
    localparam logic [2:0] LD_H    = 3'd2;
    localparam logic [2:0] LD_B    = 3'd3;
    localparam logic [2:0] LD_LWL  = 3'd4;
    localparam logic [2:0] LD_LWR  = 3'd5;

    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0a;
    localparam logic [4:0] EXC_OV   = 5'h0c;

    // Fields held by MEM; the memory-request flag is folded into the state on accept.
    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  dest;
        logic        gr_we;
        logic [31:0] alu_result;
        logic [31:0] rt_value;
        logic [2:0]  ld_op;
        logic        ld_sign;
        logic        ex;
        logic [4:0]  excode;
    } es_to_ms_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  dest;
        logic        gr_we;
        logic [31:0] final_result;
        logic        ex;
        logic [4:0]  excode;
    } ms_to_ws_t;

    localparam int ES_TO_MS_BUS_WD = $bits(es_to_ms_t);
    localparam int MS_TO_WS_BUS_WD = $bits(ms_to_ws_t);

    typedef enum logic [1:0] {
        MS_NOMEM = 2'd0,
        MS_WAIT  = 2'd1,
        MS_DONE  = 2'd2
    } ms_state_e;

    function automatic logic is_load(input logic [2:0] op);
        return (op >= LD_W) && (op <= LD_LWR);
    endfunction

endpackage

// File: rtl/mem_stage_vl_load_align.sv
// Combinational load aligner: selects, extends and merges returned word data
// for W/H/B/LWL/LWR loads given the byte offset.
module mem_stage_vl_load_align
    import mem_stage_vl_pkg::*;
(
    input  logic [2:0]  ld_op,
    input  logic        ld_sign,
    input  logic [1:0]  addr,
    input  logic [31:0] rdata,
    input  logic [31:0] rt,
    output logic [31:0] result
);

    logic [15:0] half_v;
    logic [7:0]  byte_v;

    assign half_v = rdata[{addr[1], 4'b0000} +: 16];
    assign byte_v = rdata[{addr, 3'b000} +: 8];

    always_comb begin
        // NOTE: result gets a default first so every path assigns it and no latch is inferred.
        result = rdata;
        case (ld_op)
            LD_H: result = {{16{ld_sign & half_v[15]}}, half_v};
            LD_B: result = {{24{ld_sign & byte_v[7]}}, byte_v};
            LD_LWL: begin
                case (addr)
                    2'd0:    result = {rdata[7:0],  rt[23:0]};
                    2'd1:    result = {rdata[15:0], rt[15:0]};
                    2'd2:    result = {rdata[23:0], rt[7:0]};
                    default: result = rdata;
                endcase
            end
            LD_LWR: begin
                case (addr)
                    2'd0:    result = rdata;
                    2'd1:    result = {rt[31:24], rdata[31:8]};
                    2'd2:    result = {rt[31:16], rdata[31:16]};
                    default: result = {rt[31:8],  rdata[31:24]};
                endcase
            end
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage_vl.sv
// Variable-latency MEM stage: holds an instruction until its in-order data_ok,
// aligns load data, and discards responses owed to flushed instructions.
module mem_stage_vl
    import mem_stage_vl_pkg::*;
#(
    parameter int DISCARD_MAX = 3,
    parameter bit BUF_RDATA   = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        es_to_ms_valid,
    output logic        ms_allowin,
    input  logic [31:0] es_pc,
    input  logic [4:0]  es_dest,
    input  logic        es_gr_we,
    input  logic [31:0] es_alu_result,
    input  logic [31:0] es_rt_value,
    input  logic [2:0]  es_ld_op,
    input  logic        es_ld_sign,
    input  logic        es_mem_req,
    input  logic        es_ex,
    input  logic [4:0]  es_excode,
    input  logic        es_req_inflight,
    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata,
    input  logic        ws_allowin,
    output logic        ms_to_ws_valid,
    output logic [31:0] ms_pc,
    output logic [4:0]  ms_dest,
    output logic        ms_gr_we,
    output logic [31:0] ms_final_result,
    output logic        ms_ex,
    output logic [4:0]  ms_excode,
    output logic        ms_fwd_valid,
    output logic        ms_fwd_blocked,
    output logic        ex_to_es,
    input  logic        ex_from_ws,
    output logic        ms_discard_busy
);

    localparam int CNT_W = $clog2(DISCARD_MAX + 1);
    // Two extra bits hold count + 2 before the overflow check.
    localparam int SUM_W = CNT_W + 2;
    localparam logic [SUM_W-1:0] CNT_LIMIT = SUM_W'(DISCARD_MAX);

    logic             ms_valid;
    ms_state_e        ms_state;
    es_to_ms_t        ms_bus;
    logic [31:0]      rdata_buf;
    logic [CNT_W-1:0] discard_cnt;
    logic [SUM_W-1:0] cnt_sum;

    logic        cnt_zero;
    logic        resp_drop;
    logic        resp_own;
    logic        ms_waiting;
    logic        ms_ready_go;
    logic [31:0] load_data;
    logic [31:0] align_result;
    ms_to_ws_t   ws_bus;

    // Stale responses are always claimed by the discard counter before MEM sees them.
    assign cnt_zero    = (discard_cnt == '0);
    assign resp_drop   = data_sram_data_ok && !cnt_zero;
    assign ms_waiting  = ms_valid && (ms_state == MS_WAIT);
    assign resp_own    = data_sram_data_ok && cnt_zero && ms_waiting;
    assign ms_ready_go = (ms_state == MS_NOMEM) || (ms_state == MS_DONE) || resp_own;

    assign ms_allowin      = !ms_valid || (ms_ready_go && ws_allowin);
    assign ms_to_ws_valid  = ms_valid && ms_ready_go;
    assign ms_fwd_valid    = ms_valid && ms_bus.gr_we;
    assign ms_fwd_blocked  = ms_valid && (ms_bus.ld_op != LD_NONE) && !ms_ready_go;
    assign ex_to_es        = ms_valid && ms_bus.ex;
    assign ms_discard_busy = !cnt_zero;

    always_comb begin
        cnt_sum = SUM_W'(discard_cnt);
        if (ex_from_ws) begin
            // A response arriving in the flush cycle already paid off the MEM debt.
            cnt_sum = cnt_sum + SUM_W'(ms_waiting && !resp_own) + SUM_W'(es_req_inflight);
        end
        if (resp_drop) begin
            cnt_sum = cnt_sum - SUM_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            ms_valid    <= 1'b0;
            ms_state    <= MS_NOMEM;
            discard_cnt <= '0;
            // NOTE: the payload and buffer are reset too so every WB-facing output reads 0 out of reset.
            ms_bus      <= '0;
            rdata_buf   <= '0;
        end else begin
            discard_cnt <= cnt_sum[CNT_W-1:0];
            if (ex_from_ws) begin
                ms_valid <= 1'b0;
                ms_state <= MS_NOMEM;
            end else if (ms_allowin) begin
                ms_valid <= es_to_ms_valid;
                ms_state <= (es_to_ms_valid && es_mem_req && !es_ex) ? MS_WAIT : MS_NOMEM;
                if (es_to_ms_valid) begin
                    ms_bus <= '{pc: es_pc, dest: es_dest, gr_we: es_gr_we,
                                alu_result: es_alu_result, rt_value: es_rt_value,
                                ld_op: es_ld_op, ld_sign: es_ld_sign,
                                ex: es_ex, excode: es_excode};
                end
            end else if (BUF_RDATA && resp_own) begin
                ms_state  <= MS_DONE;
                rdata_buf <= data_sram_rdata;
            end
        end
    end

    assign load_data = (ms_state == MS_DONE) ? rdata_buf : data_sram_rdata;

    mem_stage_vl_load_align u_load_align (
        .ld_op   (ms_bus.ld_op),
        .ld_sign (ms_bus.ld_sign),
        .addr    (ms_bus.alu_result[1:0]),
        .rdata   (load_data),
        .rt      (ms_bus.rt_value),
        .result  (align_result)
    );

    assign ws_bus = '{pc: ms_bus.pc, dest: ms_bus.dest, gr_we: ms_bus.gr_we,
                      final_result: is_load(ms_bus.ld_op) ? align_result : ms_bus.alu_result,
                      ex: ms_bus.ex, excode: ms_bus.excode};
    assign {ms_pc, ms_dest, ms_gr_we, ms_final_result, ms_ex, ms_excode} = ws_bus;

    a_discard_limit: assert property (@(posedge clk) disable iff (reset) cnt_sum <= CNT_LIMIT);
    a_unbuffered_wb: assert property (@(posedge clk) disable iff (reset)
                                      BUF_RDATA || !resp_own || ws_allowin);

endmodule

// File: tb/tb_mem_stage_vl.sv
// Randomized bench for mem_stage_vl against a transaction-level model of
// response ownership (stale count) and load alignment arithmetic.
`timescale 1ns/1ps
module tb_mem_stage_vl;
    import mem_stage_vl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        es_to_ms_valid, ms_allowin;
    logic [31:0] es_pc, es_alu_result, es_rt_value;
    logic [4:0]  es_dest, es_excode;
    logic        es_gr_we, es_ld_sign, es_mem_req, es_ex, es_req_inflight;
    logic [2:0]  es_ld_op;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        ws_allowin, ms_to_ws_valid;
    logic [31:0] ms_pc, ms_final_result;
    logic [4:0]  ms_dest, ms_excode;
    logic        ms_gr_we, ms_ex, ms_fwd_valid, ms_fwd_blocked, ex_to_es;
    logic        ex_from_ws, ms_discard_busy;

    mem_stage_vl #(.DISCARD_MAX(3), .BUF_RDATA(1'b1)) dut (
        .clk(clk), .reset(reset),
        .es_to_ms_valid(es_to_ms_valid), .ms_allowin(ms_allowin),
        .es_pc(es_pc), .es_dest(es_dest), .es_gr_we(es_gr_we),
        .es_alu_result(es_alu_result), .es_rt_value(es_rt_value),
        .es_ld_op(es_ld_op), .es_ld_sign(es_ld_sign), .es_mem_req(es_mem_req),
        .es_ex(es_ex), .es_excode(es_excode), .es_req_inflight(es_req_inflight),
        .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
        .ws_allowin(ws_allowin), .ms_to_ws_valid(ms_to_ws_valid),
        .ms_pc(ms_pc), .ms_dest(ms_dest), .ms_gr_we(ms_gr_we),
        .ms_final_result(ms_final_result), .ms_ex(ms_ex), .ms_excode(ms_excode),
        .ms_fwd_valid(ms_fwd_valid), .ms_fwd_blocked(ms_fwd_blocked),
        .ex_to_es(ex_to_es), .ex_from_ws(ex_from_ws), .ms_discard_busy(ms_discard_busy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int stale = 0;

    // lat/stall < 0 select random data_ok timing / random WB backpressure.
    typedef struct packed {
        logic [2:0]  op;
        logic        sign;
        logic [31:0] alu;
        logic [31:0] rt;
        logic [31:0] rdata;
        logic [31:0] pc;
        logic [4:0]  dest;
        logic [4:0]  excode;
        logic        gr_we;
        logic        ex;
        logic        mem_req;
        int          lat;
        int          stall;
        logic        flush;
        int          flush_cyc;
        logic        inflight;
    } insn_t;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        es_to_ms_valid = 1'b0; es_pc = '0; es_dest = '0; es_gr_we = 1'b0;
        es_alu_result = '0; es_rt_value = '0; es_ld_op = '0; es_ld_sign = 1'b0;
        es_mem_req = 1'b0; es_ex = 1'b0; es_excode = '0; es_req_inflight = 1'b0;
        data_sram_data_ok = 1'b0; data_sram_rdata = '0; ws_allowin = 1'b1; ex_from_ws = 1'b0;
    endtask

    function automatic insn_t mk(input logic [2:0] op, input logic sign, input logic [31:0] alu,
                                 input logic [31:0] rt, input logic [31:0] rdata);
        insn_t t;
        t.op = op; t.sign = sign; t.alu = alu; t.rt = rt; t.rdata = rdata;
        t.pc = $urandom; t.dest = 5'($urandom); t.excode = EXC_INT; t.gr_we = 1'($urandom);
        t.ex = 1'b0; t.mem_req = (op != LD_NONE);
        t.lat = -1; t.stall = -1; t.flush = 1'b0; t.flush_cyc = 0; t.inflight = 1'b0;
        return t;
    endfunction

    // Load result from byte arithmetic: shifts, masks and two's-complement wrap.
    function automatic logic [31:0] model_load(input logic [2:0] op, input logic sign, input logic [1:0] a,
                                               input logic [31:0] r, input logic [31:0] rt);
        logic [31:0] ones = '1;
        logic [31:0] v;
        int k = int'(a);
        case (op)
            LD_H: begin
                v = (r >> (16 * (k / 2))) & 32'h0000_FFFF;
                return (sign && v[15]) ? v - 32'h0001_0000 : v;
            end
            LD_B: begin
                v = (r >> (8 * k)) & 32'h0000_00FF;
                return (sign && v[7]) ? v - 32'h0000_0100 : v;
            end
            LD_LWL:  return (r << (8 * (3 - k))) | (rt & (ones >> (8 * (k + 1))));
            LD_LWR:  return (r >> (8 * k)) | (rt & ~(ones >> (8 * k)));
            default: return r;
        endcase
    endfunction

    task automatic do_reset();
        idle();
        reset = 1'b1;
        cycle();
        cycle();
        #1;
        check("rst_to_ws_valid", ms_to_ws_valid, 0);
        check("rst_allowin", ms_allowin, 1);
        check("rst_busy", ms_discard_busy, 0);
        check("rst_fwd_valid", ms_fwd_valid, 0);
        check("rst_fwd_blocked", ms_fwd_blocked, 0);
        check("rst_ex_to_es", ex_to_es, 0);
        check("rst_payload", {ms_pc, ms_dest, ms_gr_we, ms_ex, ms_excode} != '0, 0);
        check("rst_result", ms_final_result, 0);
        reset = 1'b0;
        stale = 0;
        cycle();
    endtask

    task automatic run_insn(input insn_t t);
        logic owed, dok, mine, ready, ws, fl;
        logic [31:0] cap, bus;
        int stall_left, nxt;
        bit left;
        es_pc = t.pc; es_dest = t.dest; es_gr_we = t.gr_we; es_alu_result = t.alu;
        es_rt_value = t.rt; es_ld_op = t.op; es_ld_sign = t.sign; es_mem_req = t.mem_req;
        es_ex = t.ex; es_excode = t.excode;
        es_to_ms_valid = 1'b1; data_sram_data_ok = 1'b0; ex_from_ws = 1'b0;
        es_req_inflight = 1'b0; ws_allowin = 1'($urandom);
        #1;
        check("accept_allowin", ms_allowin, 1);
        check("accept_idle_valid", ms_to_ws_valid, 0);
        check("accept_busy", ms_discard_busy, stale != 0);
        cycle();
        es_to_ms_valid = 1'b0; es_alu_result = $urandom; es_rt_value = $urandom;
        es_ld_op = 3'($urandom); es_pc = $urandom;
        owed = t.mem_req && !t.ex;
        cap = '0; stall_left = t.stall; left = 0;
        for (int cyc = 0; cyc < 64 && !left; cyc++) begin
            if (t.lat >= 0) dok = (cyc == t.lat);
            else dok = (stale > 0 || owed) && ($urandom_range(0, 1) == 1);
            mine  = dok && stale == 0 && owed;
            bus   = mine ? t.rdata : ((t.lat >= 0) ? 32'h0 : $urandom);
            ready = !owed || mine;
            ws    = (t.stall >= 0) ? !(ready && stall_left > 0) : ($urandom_range(0, 2) != 0);
            fl    = t.flush && cyc == t.flush_cyc;
            data_sram_data_ok = dok; data_sram_rdata = bus; ws_allowin = ws;
            ex_from_ws = fl; es_req_inflight = fl && t.inflight; es_to_ms_valid = fl;
            #1;
            if (fl) begin
                nxt = stale + int'(owed && !mine) + int'(t.inflight) - int'(dok && stale > 0);
                cycle();
                stale = nxt;
                idle();
                #1;
                check("flush_to_ws_valid", ms_to_ws_valid, 0);
                check("flush_allowin", ms_allowin, 1);
                check("flush_busy", ms_discard_busy, stale != 0);
                check("flush_ex_to_es", ex_to_es, 0);
                cycle();
                return;
            end
            check("to_ws_valid", ms_to_ws_valid, ready);
            check("allowin", ms_allowin, ready && ws);
            check("fwd_blocked", ms_fwd_blocked, t.op != LD_NONE && !ready);
            check("busy", ms_discard_busy, stale != 0);
            check("fwd_valid", ms_fwd_valid, t.gr_we);
            check("ex_to_es", ex_to_es, t.ex);
            if (ready) begin
                check("pc", ms_pc, t.pc);
                check("dest", ms_dest, t.dest);
                check("ex", ms_ex, t.ex);
                check("excode", ms_excode, t.excode);
                if (t.op == LD_NONE)
                    check("result_alu", ms_final_result, t.alu);
                else if (owed || t.mem_req && !t.ex)
                    check("result_load", ms_final_result,
                          model_load(t.op, t.sign, t.alu[1:0], mine ? bus : cap, t.rt));
            end
            cycle();
            if (dok) begin
                if (stale > 0) stale--;
                else if (owed) begin owed = 1'b0; cap = bus; end
            end
            if (ready && ws) left = 1;
            else if (ready && stall_left > 0) stall_left--;
        end
        idle();
    endtask

    task automatic drain();
        while (stale > 0) begin
            data_sram_data_ok = 1'b1; data_sram_rdata = $urandom;
            #1;
            check("drain_busy", ms_discard_busy, stale != 0);
            check("drain_to_ws_valid", ms_to_ws_valid, 0);
            cycle();
            stale--;
        end
        idle();
        #1;
        check("drain_clear", ms_discard_busy, stale != 0);
        cycle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        insn_t t;
        idle();
        reset = 1'b1;
        do_reset();

        t = mk(LD_W, 1'b0, 32'h0000_1000, 32'h0, 32'hDEAD_BEEF); t.lat = 3; t.stall = 0; run_insn(t);
        t = mk(LD_B, 1'b1, 32'h0000_1003, 32'h0, 32'h8012_3456); t.lat = 0; t.stall = 0; run_insn(t);
        t = mk(LD_B, 1'b0, 32'h0000_1003, 32'h0, 32'h8012_3456); t.lat = 1; t.stall = 0; run_insn(t);
        t = mk(LD_LWL, 1'b0, 32'h0000_2001, 32'h1122_3344, 32'hAABB_CCDD); t.lat = 0; t.stall = 0; run_insn(t);
        t = mk(LD_LWR, 1'b0, 32'h0000_2001, 32'h1122_3344, 32'hAABB_CCDD); t.lat = 2; t.stall = 0; run_insn(t);
        t = mk(LD_NONE, 1'b0, 32'h0000_55AA, 32'h0, 32'h0); t.stall = 0; run_insn(t);

        // Flush in WAIT with a request still in EX: the next LW owns only the third response.
        t = mk(LD_W, 1'b0, 32'h0000_4000, 32'h0, 32'h0BAD_0BAD); t.lat = 10;
        t.flush = 1'b1; t.flush_cyc = 1; t.inflight = 1'b1; run_insn(t);
        t = mk(LD_W, 1'b0, 32'h0000_4004, 32'h0, 32'h1234_5678); t.stall = 0; run_insn(t);

        t = mk(LD_W, 1'b0, 32'h0000_3000, 32'h0, 32'hCAFE_F00D); t.lat = 1; t.stall = 3; run_insn(t);

        t = mk(LD_W, 1'b0, 32'h0000_5000, 32'h0, 32'h7777_7777); t.lat = 2;
        t.flush = 1'b1; t.flush_cyc = 2; run_insn(t);
        t = mk(LD_H, 1'b1, 32'h0000_5002, 32'h0, 32'h8001_7FFF); t.lat = 0; t.stall = 0; run_insn(t);

        // Reset while discards are pending clears the count along with the bus.
        t = mk(LD_W, 1'b0, 32'h0000_6000, 32'h0, 32'h0); t.lat = 10;
        t.flush = 1'b1; t.flush_cyc = 0; t.inflight = 1'b1; run_insn(t);
        do_reset();
        t = mk(LD_W, 1'b0, 32'h0000_6004, 32'h0, 32'h600D_600D); t.lat = 0; t.stall = 0; run_insn(t);

        for (int n = 0; n < 300; n++) begin
            t = mk(3'($urandom_range(0, 5)), 1'($urandom), $urandom, $urandom, $urandom);
            if ($urandom_range(0, 7) == 0) begin t.ex = 1'b1; t.excode = EXC_ADEL; end
            if (stale <= 1 && $urandom_range(0, 5) == 0) begin
                t.flush = 1'b1; t.flush_cyc = $urandom_range(0, 3); t.inflight = 1'($urandom);
            end
            run_insn(t);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
